// File: rtl/pipeline_hazard_ctrl.sv
// Interlock and forwarding controller for a 5-stage in-order pipeline.
// Tracks the destination registers of the instructions in EX, MEM and WB.
// Produces the stall, flush and bubble controls and the registered EX operand
// forwarding selects.
// Serializes CSR/MRET/ECALL by draining the back end before issuing them.
// Keeps a saturating count of front-end stall cycles.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [1:0]       id_uses_reg,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_wen,
    input  logic [1:0]       id_wbsel,
    input  logic             id_serial,
    input  logic             ex_redirect,
    input  logic             mem_stall,
    output logic             stall_front,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             freeze_back,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             serial_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
    } trk_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    // A tracker entry supplies a source only for a real, writing, non-x0 producer.
    function automatic logic src_hit(trk_t e, logic [4:0] rs, logic used);
        return e.vld && e.wen && (e.rd != 5'd0) && (e.rd == rs) && used;
    endfunction

    // The youngest producer wins; a load in EX cannot forward (load-use stall covers it).
    function automatic logic [1:0] fwd_sel(logic ex_hit, logic ex_ld, logic mem_hit);
        if (ex_hit && !ex_ld) begin
            return 2'b01;
        end else if (mem_hit) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    trk_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_ent;
    state_t           state_q, state_d;
    logic             redir_pend_q, redir_pend_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic any_vld, redirect, serial_req, load_use;
    logic a_ex_hit, a_mem_hit, b_ex_hit, b_mem_hit;

    assign id_ent     = {id_valid, id_rd, id_reg_wen, id_reg_wen & (id_wbsel == 2'b00)};
    assign any_vld    = ex_q.vld | mem_q.vld | wb_q.vld;
    // A redirect that arrived while the back end was frozen is remembered until release.
    assign redirect   = ex_redirect | redir_pend_q;
    assign serial_req = id_valid & id_serial & any_vld;
    assign a_ex_hit   = src_hit(ex_q,  id_rs1, id_uses_reg[0]);
    assign a_mem_hit  = src_hit(mem_q, id_rs1, id_uses_reg[0]);
    assign b_ex_hit   = src_hit(ex_q,  id_rs2, id_uses_reg[1]);
    assign b_mem_hit  = src_hit(mem_q, id_rs2, id_uses_reg[1]);
    assign load_use   = ex_q.ld & (a_ex_hit | b_ex_hit);

    assign fwd_a        = fwd_a_q;
    assign fwd_b        = fwd_b_q;
    assign stall_cycles = cnt_q;
    assign serial_busy  = rst_n & (state_q != S_RUN);

    // Pipeline controls, resolved in priority order: reset, memory freeze, redirect, serialize, load-use.
    always_comb begin
        stall_front  = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        freeze_back  = 1'b0;
        if (!rst_n) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (mem_stall) begin
            freeze_back  = 1'b1;
            stall_front  = 1'b1;
        end else if (redirect) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if ((state_q == S_DRAIN) || ((state_q == S_RUN) && serial_req)) begin
            stall_front  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (load_use) begin
            stall_front  = 1'b1;
            bubble_id_ex = 1'b1;
        end
    end

    // Serialize FSM next state and the pending-redirect latch.
    always_comb begin
        state_d      = state_q;
        redir_pend_d = 1'b0;
        if (mem_stall) begin
            redir_pend_d = redir_pend_q | ex_redirect;
        end else if (redirect) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN:   if (serial_req) state_d = S_DRAIN;
                S_DRAIN: if (!any_vld)   state_d = S_ISSUE;
                S_ISSUE: state_d = S_RUN;
                default: state_d = S_RUN;
            endcase
        end
    end

    // Tracker advance, forwarding-select capture and stall counting.
    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        cnt_d   = stall_front ? sat_inc(cnt_q) : cnt_q;
        if (!mem_stall) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (bubble_id_ex) begin
                ex_d    = '0;
                fwd_a_d = 2'b00;
                fwd_b_d = 2'b00;
            end else begin
                ex_d    = id_ent;
                fwd_a_d = fwd_sel(a_ex_hit, ex_q.ld, a_mem_hit);
                fwd_b_d = fwd_sel(b_ex_hit, ex_q.ld, b_mem_hit);
            end
        end
    end

    // Tracker registers; only the valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        ex_q  <= ex_d;
        mem_q <= mem_d;
        wb_q  <= wb_d;
        if (!rst_n) begin
            ex_q.vld  <= 1'b0;
            mem_q.vld <= 1'b0;
            wb_q.vld  <= 1'b0;
        end
    end

    // Control state registers; reset abandons any drain in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            redir_pend_q <= 1'b0;
            fwd_a_q      <= 2'b00;
            fwd_b_q      <= 2'b00;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= redir_pend_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of in-flight instructions.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, id_reg_wen, id_serial, ex_redirect, mem_stall;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_uses_reg, id_wbsel;
    logic        stall_front, flush_if_id, bubble_id_ex, freeze_back, serial_busy;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_reg(id_uses_reg), .id_rd(id_rd), .id_reg_wen(id_reg_wen), .id_wbsel(id_wbsel),
        .id_serial(id_serial), .ex_redirect(ex_redirect), .mem_stall(mem_stall),
        .stall_front(stall_front), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
        .freeze_back(freeze_back), .fwd_a(fwd_a), .fwd_b(fwd_b), .serial_busy(serial_busy),
        .stall_cycles(stall_cycles)
    );

    int    n_assert = 0;
    int    n_fail   = 0;
    string cur_tag  = "init";

    // Model: in-flight instructions indexed by age (0 = in EX, 1 = MEM, 2 = WB).
    typedef struct { bit v; bit [4:0] rd; bit w; bit ld; } inst_t;
    inst_t    pipe [3];
    bit       m_wait;   // serial instruction held in ID until the back end is empty
    bit       m_go;     // back end empty: serial instruction is released this cycle
    bit       m_pend;   // redirect seen during a memory freeze
    bit [1:0] m_fa, m_fb;
    int       m_cnt;
    bit       e_stall, e_flush, e_bub, e_freeze, e_busy;
    logic     o_stall, o_flush, o_bub, o_freeze, o_busy;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s/%s: observed 0x%0h, expected 0x%0h", cur_tag, name, obs, exp);
            $error("check %s/%s", cur_tag, name);
        end
    endtask

    function automatic bit hit(int age, logic [4:0] rs, logic used);
        return pipe[age].v && pipe[age].w && (pipe[age].rd != 0) && (pipe[age].rd == rs) && used;
    endfunction

    function automatic bit [1:0] src_of(logic [4:0] rs, logic used);
        if (hit(0, rs, used) && !pipe[0].ld) return 2'b01;
        if (hit(1, rs, used)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_comb();
        bit any;
        any = pipe[0].v || pipe[1].v || pipe[2].v;
        {e_stall, e_flush, e_bub, e_freeze} = 4'b0000;
        if (!rst_n) begin
            e_flush = 1; e_bub = 1;
        end else if (mem_stall) begin
            e_freeze = 1; e_stall = 1;
        end else if (ex_redirect || m_pend) begin
            e_flush = 1; e_bub = 1;
        end else if (m_wait || (!m_go && id_valid && id_serial && any)) begin
            e_stall = 1; e_bub = 1;
        end else if (pipe[0].ld && (hit(0, id_rs1, id_uses_reg[0]) || hit(0, id_rs2, id_uses_reg[1]))) begin
            e_stall = 1; e_bub = 1;
        end
        e_busy = rst_n && (m_wait || m_go);
    endtask

    task automatic model_edge();
        bit       redir, any;
        bit [1:0] fa, fb;
        inst_t    ni;
        any = pipe[0].v || pipe[1].v || pipe[2].v;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
            m_wait = 0; m_go = 0; m_pend = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
        end else begin
            if (e_stall && m_cnt < 65535) m_cnt++;
            if (mem_stall) begin
                m_pend = m_pend || ex_redirect;
            end else begin
                redir  = ex_redirect || m_pend;
                m_pend = 0;
                fa = src_of(id_rs1, id_uses_reg[0]);
                fb = src_of(id_rs2, id_uses_reg[1]);
                if (redir) begin
                    m_wait = 0; m_go = 0;
                end else if (m_wait) begin
                    if (!any) begin m_wait = 0; m_go = 1; end
                end else if (m_go) begin
                    m_go = 0;
                end else if (id_valid && id_serial && any) begin
                    m_wait = 1;
                end
                ni = '{id_valid, id_rd, id_reg_wen, id_reg_wen && (id_wbsel == 2'b00)};
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = e_bub ? '{0, 0, 0, 0} : ni;
                m_fa = e_bub ? 2'b00 : fa;
                m_fb = e_bub ? 2'b00 : fb;
            end
        end
    endtask

    // One clock: compare every output with the model mid-cycle, then advance both.
    task automatic step();
        @(negedge clk);
        model_comb();
        o_stall = stall_front; o_flush = flush_if_id; o_bub = bubble_id_ex;
        o_freeze = freeze_back; o_busy = serial_busy;
        chk("stall_front", stall_front, e_stall);
        chk("flush_if_id", flush_if_id, e_flush);
        chk("bubble_id_ex", bubble_id_ex, e_bub);
        chk("freeze_back", freeze_back, e_freeze);
        chk("serial_busy", serial_busy, e_busy);
        chk("fwd_a", fwd_a, m_fa);
        chk("fwd_b", fwd_b, m_fb);
        chk("stall_cycles", stall_cycles, m_cnt);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            model_comb();
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic set_id(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit [1:0] u,
                          input bit [4:0] rd, input bit w, input bit [1:0] wb, input bit ser);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_uses_reg = u;
        id_rd = rd; id_reg_wen = w; id_wbsel = wb; id_serial = ser;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 2'b00, 0, 0, 2'b00, 0);
    endtask

    initial begin
        #10000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int drain;
        bit issued;
        int c0;
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        m_wait = 0; m_go = 0; m_pend = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
        rst_n = 0; ex_redirect = 0; mem_stall = 0;
        idle();
        @(posedge clk); #1;

        cur_tag = "reset";
        step();
        chk("rst_flush", o_flush, 1); chk("rst_bubble", o_bub, 1);
        chk("rst_stall", o_stall, 0); chk("rst_busy", o_busy, 0);
        chk("rst_cnt", stall_cycles, 0); chk("rst_fwd_a", fwd_a, 0);
        rst_n = 1;
        step();
        chk("post_rst_stall", o_stall, 0);

        cur_tag = "loaduse";
        set_id(1, 1, 0, 2'b01, 5, 1, 2'b00, 0);          // lw x5,0(x1)
        step();
        set_id(1, 5, 2, 2'b11, 6, 1, 2'b01, 0);          // add x6,x5,x2
        step();
        chk("lu_stall", o_stall, 1); chk("lu_bubble", o_bub, 1); chk("lu_cnt", stall_cycles, 1);
        step();
        chk("lu_issue", o_stall, 0); chk("lu_fwd_a", fwd_a, 2'b10); chk("lu_fwd_b", fwd_b, 2'b00);
        chk("lu_cnt2", stall_cycles, 1);

        cur_tag = "fwd_ex";
        set_id(1, 0, 0, 2'b01, 3, 1, 2'b01, 0); step(); // addi x3,x0,7
        set_id(1, 3, 3, 2'b11, 4, 1, 2'b01, 0); step(); // add x4,x3,x3
        chk("stall", o_stall, 0); chk("fwd_a", fwd_a, 2'b01); chk("fwd_b", fwd_b, 2'b01);
        cur_tag = "fwd_mem";
        set_id(1, 0, 0, 2'b01, 3, 1, 2'b01, 0); step();
        set_id(1, 0, 0, 2'b01, 7, 1, 2'b01, 0); step();
        set_id(1, 3, 3, 2'b11, 4, 1, 2'b01, 0); step();
        chk("stall", o_stall, 0); chk("fwd_a", fwd_a, 2'b10); chk("fwd_b", fwd_b, 2'b10);
        cur_tag = "fwd_x0";
        set_id(1, 0, 0, 2'b01, 0, 1, 2'b01, 0); step();
        set_id(1, 0, 0, 2'b11, 4, 1, 2'b01, 0); step();
        chk("fwd_a", fwd_a, 2'b00); chk("fwd_b", fwd_b, 2'b00);

        cur_tag = "serial";
        set_id(1, 0, 0, 2'b01, 10, 1, 2'b01, 0); step();
        set_id(1, 0, 0, 2'b01, 11, 1, 2'b01, 0); step();
        set_id(1, 0, 0, 2'b01, 12, 1, 2'b01, 0); step();
        set_id(1, 1, 0, 2'b01, 13, 1, 2'b11, 1);         // csrrw x13
        step();
        chk("entry_stall", o_stall, 1); chk("entry_busy", o_busy, 0);
        drain = 0; issued = 0;
        for (int i = 0; i < 10 && !issued; i++) begin
            step();
            if (o_busy && o_stall) drain++;
            else if (o_busy && !o_stall) issued = 1;
        end
        chk("drain_cycles", drain, 3); chk("issued", issued, 1);
        idle(); step();
        chk("back_to_run", o_busy, 0);

        cur_tag = "redir_lu";
        set_id(1, 1, 0, 2'b01, 5, 1, 2'b00, 0); step();
        set_id(1, 5, 2, 2'b11, 6, 1, 2'b01, 0); ex_redirect = 1; step();
        chk("flush", o_flush, 1); chk("bubble", o_bub, 1); chk("stall", o_stall, 0);
        ex_redirect = 0; idle(); step();
        chk("no_extra_stall", o_stall, 0);

        cur_tag = "memstall";
        set_id(1, 0, 0, 2'b01, 3, 1, 2'b01, 0); step();
        set_id(1, 3, 3, 2'b11, 4, 1, 2'b01, 0); step();
        c0 = m_cnt; idle();
        mem_stall = 1; ex_redirect = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("freeze", o_freeze, 1); chk("stall", o_stall, 1); chk("no_flush", o_flush, 0);
            chk("fwd_held", fwd_a, 2'b01);
        end
        chk("cnt_plus4", stall_cycles, c0 + 4);
        mem_stall = 0; ex_redirect = 0; step();
        chk("late_flush", o_flush, 1); chk("late_bubble", o_bub, 1); chk("unfreeze", o_freeze, 0);
        step();
        chk("flush_once", o_flush, 0);

        cur_tag = "rst_drain";
        set_id(1, 0, 0, 2'b01, 10, 1, 2'b01, 0); step();
        set_id(1, 0, 0, 2'b01, 11, 1, 2'b01, 0); step();
        set_id(1, 1, 0, 2'b01, 13, 1, 2'b11, 1); step();
        step();
        chk("in_drain", o_busy, 1);
        rst_n = 0; step();
        chk("flush", o_flush, 1); chk("bubble", o_bub, 1); chk("stall", o_stall, 0);
        chk("busy", o_busy, 0); chk("freeze", o_freeze, 0);
        chk("cnt_clr", stall_cycles, 0); chk("fwd_a_clr", fwd_a, 0); chk("fwd_b_clr", fwd_b, 0);
        rst_n = 1; step();
        chk("direct_issue", o_stall, 0); chk("run", o_busy, 0);
        idle();

        cur_tag = "rand";
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            mem_stall   = ($urandom_range(0, 99) < 8);
            ex_redirect = ($urandom_range(0, 99) < 5);
            set_id($urandom_range(0, 99) < 85, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                   2'($urandom_range(0, 3)), 5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), $urandom_range(0, 99) < 3);
            step();
        end

        cur_tag = "saturate";
        rst_n = 0; mem_stall = 0; ex_redirect = 0; idle(); step();
        rst_n = 1; mem_stall = 1;
        run_quiet(65534);
        chk("cnt_fffe", stall_cycles, 16'hFFFE);
        for (int i = 0; i < 3; i++) step();
        chk("cnt_sat", stall_cycles, 16'hFFFF);
        mem_stall = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
